// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The datapath (master) drives hazard sources and reads back enables, state and counters.
interface hazard_stall_ctrl_if;
    logic [4:0]  IfIdRs;
    logic [4:0]  IfIdRt;
    logic        IfId_usesRt;
    logic        IfId_isBranchType;
    logic        branch_taken;
    logic [4:0]  IdExRd;
    logic [4:0]  ExMemRd;
    logic        IdEx_RegWrite;
    logic        IdEx_MemRead;
    logic        ExMem_MemRead;
    logic        ICache_stall;
    logic        DCache_stall;
    logic        PC_write;
    logic        IfId_write;
    logic        ExMem_write;
    logic        MemWb_write;
    logic        IdEx_bubble;
    logic        IfId_flush;
    logic [1:0]  hz_state;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] freeze_events;

    modport slave (
        input  IfIdRs, IfIdRt, IfId_usesRt, IfId_isBranchType, branch_taken,
        input  IdExRd, ExMemRd, IdEx_RegWrite, IdEx_MemRead, ExMem_MemRead,
        input  ICache_stall, DCache_stall,
        output PC_write, IfId_write, ExMem_write, MemWb_write,
        output IdEx_bubble, IfId_flush, hz_state,
        output stall_cycles, flush_count, freeze_events
    );

    modport master (
        output IfIdRs, IfIdRt, IfId_usesRt, IfId_isBranchType, branch_taken,
        output IdExRd, ExMemRd, IdEx_RegWrite, IdEx_MemRead, ExMem_MemRead,
        output ICache_stall, DCache_stall,
        input  PC_write, IfId_write, ExMem_write, MemWb_write,
        input  IdEx_bubble, IfId_flush, hz_state,
        input  stall_cycles, flush_count, freeze_events
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detection and stall/flush control with a RUN/STALL/FREEZE
// status register and saturating performance counters.
module hazard_stall_ctrl (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FREEZE = 2'b10
    } hz_state_t;

    hz_state_t   state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] freeze_cnt;

    logic freeze;
    logic idex_match;
    logic exmem_match;
    logic load_use;
    logic br_haz;
    logic hazard;

    // A register reaching $zero never creates a dependence.
    assign idex_match  = (bus.IdExRd != 5'd0) &&
                         ((bus.IdExRd == bus.IfIdRs) ||
                          (bus.IfId_usesRt && (bus.IdExRd == bus.IfIdRt)));
    assign exmem_match = (bus.ExMemRd != 5'd0) &&
                         ((bus.ExMemRd == bus.IfIdRs) ||
                          (bus.IfId_usesRt && (bus.ExMemRd == bus.IfIdRt)));

    assign freeze   = bus.ICache_stall | bus.DCache_stall;
    assign load_use = bus.IdEx_MemRead & idex_match;
    assign br_haz   = bus.IfId_isBranchType &
                      ((bus.IdEx_RegWrite & idex_match) |
                       (bus.ExMem_MemRead & exmem_match));
    assign hazard   = (load_use | br_haz) & ~freeze;

    always_comb begin
        bus.PC_write    = 1'b1;
        bus.IfId_write  = 1'b1;
        bus.ExMem_write = 1'b1;
        bus.MemWb_write = 1'b1;
        bus.IdEx_bubble = 1'b0;
        bus.IfId_flush  = 1'b0;
        if (freeze) begin
            bus.PC_write    = 1'b0;
            bus.IfId_write  = 1'b0;
            bus.ExMem_write = 1'b0;
            bus.MemWb_write = 1'b0;
        end else if (hazard) begin
            // Hold fetch/decode, let older stages drain; a held branch flushes later.
            bus.PC_write    = 1'b0;
            bus.IfId_write  = 1'b0;
            bus.IdEx_bubble = 1'b1;
        end else begin
            bus.IfId_flush  = bus.branch_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            stall_cnt  <= 32'd0;
            flush_cnt  <= 32'd0;
            freeze_cnt <= 32'd0;
        end else begin
            if (freeze)
                state <= FREEZE;
            else if (hazard)
                state <= STALL;
            else
                state <= RUN;

            if ((freeze || hazard) && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.IfId_flush && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
            // Rising edge of freeze is seen against the registered state.
            if (freeze && (state != FREEZE) && (freeze_cnt != 32'hFFFF_FFFF))
                freeze_cnt <= freeze_cnt + 32'd1;
        end
    end

    assign bus.hz_state      = state;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.flush_count   = flush_cnt;
    assign bus.freeze_events = freeze_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios plus
// randomized cycles compared against a rule-level reference model.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic [31:0] m_freeze;
    logic [1:0]  m_state;
    logic [1:0]  exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic m_match(input logic [4:0] r);
        return (r != 5'd0) && ((r == bus.IfIdRs) || (bus.IfId_usesRt && (r == bus.IfIdRt)));
    endfunction

    function automatic logic m_freeze_now();
        return bus.ICache_stall || bus.DCache_stall;
    endfunction

    function automatic logic m_hazard_now();
        logic lu;
        logic bh;
        lu = bus.IdEx_MemRead && m_match(bus.IdExRd);
        bh = bus.IfId_isBranchType &&
             ((bus.IdEx_RegWrite && m_match(bus.IdExRd)) ||
              (bus.ExMem_MemRead && m_match(bus.ExMemRd)));
        return (lu || bh) && !m_freeze_now();
    endfunction

    // {PC_write, IfId_write, ExMem_write, MemWb_write, IdEx_bubble, IfId_flush}
    function automatic logic [5:0] m_ctrl();
        if (m_freeze_now()) return 6'b000000;
        if (m_hazard_now()) return 6'b001110;
        return {5'b11110, bus.branch_taken};
    endfunction

    function automatic logic [5:0] dut_ctrl();
        return {bus.PC_write, bus.IfId_write, bus.ExMem_write, bus.MemWb_write,
                bus.IdEx_bubble, bus.IfId_flush};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_stall  = 32'd0;
        m_flush  = 32'd0;
        m_freeze = 32'd0;
        m_state  = 2'b00;
    endtask

    task automatic idle();
        bus.IfIdRs = 5'd0;
        bus.IfIdRt = 5'd0;
        bus.IfId_usesRt = 1'b0;
        bus.IfId_isBranchType = 1'b0;
        bus.branch_taken = 1'b0;
        bus.IdExRd = 5'd0;
        bus.ExMemRd = 5'd0;
        bus.IdEx_RegWrite = 1'b0;
        bus.IdEx_MemRead = 1'b0;
        bus.ExMem_MemRead = 1'b0;
        bus.ICache_stall = 1'b0;
        bus.DCache_stall = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs present before the edge.
    task automatic tick();
        logic f;
        logic h;
        logic [5:0] c;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            f = m_freeze_now();
            h = m_hazard_now();
            c = m_ctrl();
            if (f || h) m_stall = sat_inc(m_stall);
            if (c[0]) m_flush = sat_inc(m_flush);
            if (f && (m_state != 2'b10)) m_freeze = sat_inc(m_freeze);
            m_state = f ? 2'b10 : (h ? 2'b01 : 2'b00);
        end
        exp_q.push_back(m_state);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.hz_state !== 2'b00 || bus.stall_cycles !== 32'd0 ||
            bus.flush_count !== 32'd0 || bus.freeze_events !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: state=%b stall=%0d flush=%0d frz=%0d, want all 0",
                     bus.hz_state, bus.stall_cycles, bus.flush_count, bus.freeze_events);
        end
        checks++;
        if (dut_ctrl() !== 6'b111100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 111100", dut_ctrl());
        end
        // Combinational path stays live while in reset.
        bus.DCache_stall = 1'b1;
        #1;
        checks++;
        if (dut_ctrl() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_comb_live: got %b want 000000", dut_ctrl());
        end
        tick();
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.freeze_events !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_count: stall=%0d frz=%0d want 0", bus.stall_cycles, bus.freeze_events);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.IdEx_MemRead = 1'b1;
        bus.IdExRd = 5'd8;
        bus.IfIdRs = 5'd8;
        #1;
        checks++;
        if (dut_ctrl() !== 6'b001110) begin
            errors++;
            $display("FAIL load_use_ctrl: got %b want 001110", dut_ctrl());
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.hz_state !== 2'b01 || bus.stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_use_state: state=%b stall=%0d want 01/1", bus.hz_state, bus.stall_cycles);
        end
        tick();
    endtask

    task automatic test_load_branch();
        logic [31:0] s0;
        idle();
        s0 = m_stall;
        bus.IfId_isBranchType = 1'b1;
        bus.IfIdRs = 5'd9;
        bus.IfIdRt = 5'd3;
        bus.IfId_usesRt = 1'b1;
        bus.IdEx_MemRead = 1'b1;
        bus.IdEx_RegWrite = 1'b1;
        bus.IdExRd = 5'd9;
        #1;
        checks++;
        if (bus.PC_write !== 1'b0 || bus.IdEx_bubble !== 1'b1) begin
            errors++;
            $display("FAIL lbr_stall1: pc=%b bub=%b want 0/1", bus.PC_write, bus.IdEx_bubble);
        end
        tick();
        // The load moved to MEM; a bubble now occupies EX.
        bus.IdEx_MemRead = 1'b0;
        bus.IdEx_RegWrite = 1'b0;
        bus.IdExRd = 5'd0;
        bus.ExMem_MemRead = 1'b1;
        bus.ExMemRd = 5'd9;
        #1;
        checks++;
        if (bus.PC_write !== 1'b0 || bus.IdEx_bubble !== 1'b1) begin
            errors++;
            $display("FAIL lbr_stall2: pc=%b bub=%b want 0/1", bus.PC_write, bus.IdEx_bubble);
        end
        tick();
        bus.ExMem_MemRead = 1'b0;
        bus.ExMemRd = 5'd0;
        #1;
        checks++;
        if (bus.PC_write !== 1'b1 || bus.stall_cycles !== s0 + 32'd2 || bus.hz_state !== 2'b01) begin
            errors++;
            $display("FAIL lbr_release: pc=%b stall=%0d state=%b want 1/%0d/01",
                     bus.PC_write, bus.stall_cycles, bus.hz_state, s0 + 32'd2);
        end
        tick();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        bus.IdEx_MemRead = 1'b1;
        bus.IdEx_RegWrite = 1'b1;
        bus.IfId_isBranchType = 1'b1;
        bus.IfId_usesRt = 1'b1;
        #1;
        checks++;
        if (dut_ctrl() !== 6'b111100) begin
            errors++;
            $display("FAIL zero_reg: got %b want 111100", dut_ctrl());
        end
        tick();
        checks++;
        if (bus.hz_state !== 2'b00) begin
            errors++;
            $display("FAIL zero_reg_state: got %b want 00", bus.hz_state);
        end
        idle();
    endtask

    task automatic test_dcache_freeze();
        do_reset();
        bus.IdEx_MemRead = 1'b1;
        bus.IdExRd = 5'd12;
        bus.IfIdRs = 5'd12;
        bus.DCache_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (dut_ctrl() !== 6'b000000) begin
                errors++;
                $display("FAIL freeze_ctrl[%0d]: got %b want 000000", i, dut_ctrl());
            end
            tick();
        end
        checks++;
        if (bus.hz_state !== 2'b10 || bus.freeze_events !== 32'd1 || bus.stall_cycles !== 32'd5) begin
            errors++;
            $display("FAIL freeze_regs: state=%b frz=%0d stall=%0d want 10/1/5",
                     bus.hz_state, bus.freeze_events, bus.stall_cycles);
        end
        bus.DCache_stall = 1'b0;
        #1;
        checks++;
        if (dut_ctrl() !== 6'b001110) begin
            errors++;
            $display("FAIL freeze_then_lu: got %b want 001110", dut_ctrl());
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.hz_state !== 2'b01 || bus.stall_cycles !== 32'd6 || dut_ctrl() !== 6'b111100) begin
            errors++;
            $display("FAIL freeze_after: state=%b stall=%0d ctrl=%b want 01/6/111100",
                     bus.hz_state, bus.stall_cycles, dut_ctrl());
        end
        tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        bus.IfId_isBranchType = 1'b1;
        bus.branch_taken = 1'b1;
        bus.IfIdRs = 5'd5;
        #1;
        checks++;
        if (bus.IfId_flush !== 1'b1) begin
            errors++;
            $display("FAIL br_flush: got %b want 1", bus.IfId_flush);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.flush_count !== 32'd1 || bus.IfId_flush !== 1'b0) begin
            errors++;
            $display("FAIL br_flush_cnt: cnt=%0d flush=%b want 1/0", bus.flush_count, bus.IfId_flush);
        end
        bus.IfId_isBranchType = 1'b1;
        bus.branch_taken = 1'b1;
        bus.IfIdRs = 5'd5;
        bus.IdEx_RegWrite = 1'b1;
        bus.IdExRd = 5'd5;
        #1;
        checks++;
        if (bus.IfId_flush !== 1'b0 || bus.IdEx_bubble !== 1'b1) begin
            errors++;
            $display("FAIL br_held: flush=%b bub=%b want 0/1", bus.IfId_flush, bus.IdEx_bubble);
        end
        tick();
        bus.IdEx_RegWrite = 1'b0;
        bus.IdExRd = 5'd0;
        #1;
        checks++;
        if (bus.IfId_flush !== 1'b1) begin
            errors++;
            $display("FAIL br_proceed: flush=%b want 1", bus.IfId_flush);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.flush_count !== 32'd2 || bus.stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL br_counts: flush=%0d stall=%0d want 2/1", bus.flush_count, bus.stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [1:0] e;
        idle();
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            bus.IfIdRs = 5'($urandom_range(0, 3));
            bus.IfIdRt = 5'($urandom_range(0, 3));
            bus.IfId_usesRt = 1'($urandom_range(0, 1));
            bus.IfId_isBranchType = 1'($urandom_range(0, 1));
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.IdExRd = 5'($urandom_range(0, 3));
            bus.ExMemRd = 5'($urandom_range(0, 3));
            bus.IdEx_RegWrite = 1'($urandom_range(0, 1));
            bus.IdEx_MemRead = 1'($urandom_range(0, 1));
            bus.ExMem_MemRead = 1'($urandom_range(0, 1));
            bus.ICache_stall = ($urandom_range(0, 9) == 0);
            bus.DCache_stall = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (dut_ctrl() !== m_ctrl()) begin
                errors++;
                $display("FAIL rnd_ctrl[%0d]: got %b want %b", n, dut_ctrl(), m_ctrl());
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.hz_state !== e || bus.stall_cycles !== m_stall ||
                bus.flush_count !== m_flush || bus.freeze_events !== m_freeze) begin
                errors++;
                $display("FAIL rnd_regs[%0d]: state=%b/%b stall=%0d/%0d flush=%0d/%0d frz=%0d/%0d (got/want)",
                         n, bus.hz_state, e, bus.stall_cycles, m_stall, bus.flush_count, m_flush,
                         bus.freeze_events, m_freeze);
            end
        end
        idle();
    endtask

    task automatic test_saturation_reset();
        idle();
        bus.ICache_stall = 1'b1;
        force dut.stall_cnt = 32'hFFFF_FFFC;
        #1;
        release dut.stall_cnt;
        m_stall = 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.stall_cycles !== 32'hFFFF_FFFF || bus.hz_state !== 2'b10) begin
            errors++;
            $display("FAIL sat_hold: stall=%h state=%b want ffffffff/10", bus.stall_cycles, bus.hz_state);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 ||
            bus.freeze_events !== 32'd0 || bus.hz_state !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_freeze: stall=%0d flush=%0d frz=%0d state=%b want 0",
                     bus.stall_cycles, bus.flush_count, bus.freeze_events, bus.hz_state);
        end
        checks++;
        if (dut_ctrl() !== 6'b000000) begin
            errors++;
            $display("FAIL rst_freeze_comb: got %b want 000000", dut_ctrl());
        end
        tick();
        bus.ICache_stall = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.freeze_events !== 32'd0 || bus.hz_state !== 2'b00 || bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL post_rst: frz=%0d state=%b stall=%0d want 0/00/0",
                     bus.freeze_events, bus.hz_state, bus.stall_cycles);
        end
        bus.ICache_stall = 1'b1;
        tick();
        checks++;
        if (bus.freeze_events !== 32'd1 || bus.hz_state !== 2'b10) begin
            errors++;
            $display("FAIL post_rst_freeze: frz=%0d state=%b want 1/10", bus.freeze_events, bus.hz_state);
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_load_branch();
        test_zero_reg();
        test_dcache_freeze();
        test_branch_flush();
        test_random();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
